// File: rtl/dtl_gm_responder.sv
// DTL slave terminating the core's global-memory master port onto a synchronous SRAM.
// Supports single/block reads and writes at one beat per cycle, with a 2-entry read FIFO for back-pressure.
module dtl_gm_responder #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int GM_MEM_ADDR_WIDTH     = 10
) (
    input  logic                               iClk,
    input  logic                               iReset,
    input  logic                               iDTL_DMEM_CommandValid,
    output logic                               oDTL_DMEM_CommandAccept,
    input  logic                               iDTL_DMEM_CommandReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]    iDTL_DMEM_Address,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0]   iDTL_DMEM_BlockSize,
    input  logic                               iDTL_DMEM_WriteValid,
    output logic                               oDTL_DMEM_WriteAccept,
    input  logic [INTERFACE_WIDTH-1:0]         iDTL_DMEM_WriteData,
    input  logic [INTERFACE_WIDTH/8-1:0]       iDTL_DMEM_WriteEnable,
    input  logic                               iDTL_DMEM_WriteLast,
    output logic                               oDTL_DMEM_ReadValid,
    input  logic                               iDTL_DMEM_ReadAccept,
    output logic [INTERFACE_WIDTH-1:0]         oDTL_DMEM_ReadData,
    output logic                               oDTL_DMEM_ReadLast,
    output logic [GM_MEM_ADDR_WIDTH-1:0]       oMem_WriteAddress,
    output logic [INTERFACE_WIDTH/8-1:0]       oMem_WriteEnable,
    output logic [INTERFACE_WIDTH-1:0]         oMem_WriteData,
    output logic [GM_MEM_ADDR_WIDTH-1:0]       oMem_ReadAddress,
    output logic                               oMem_ReadEnable,
    input  logic [INTERFACE_WIDTH-1:0]         iMem_ReadData,
    output logic                               oError
);
    localparam int CNT_W = INTERFACE_BLOCK_WIDTH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    state_t                         state_q;
    logic [GM_MEM_ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]               left_q;
    logic                           inflight_q;
    logic                           inflight_last_q;
    logic [INTERFACE_WIDTH-1:0]     fifo_data_q [2];
    logic [1:0]                     fifo_last_q;
    logic                           rd_ptr_q;
    logic                           wr_ptr_q;
    logic [1:0]                     fifo_cnt_q;
    logic                           error_q;

    logic       wr_beat;
    logic       wr_final;
    logic       rd_valid;
    logic       rd_pop;
    logic       rd_issue;
    logic [2:0] occupancy_d;
    logic       unused_addr;

    // Byte-offset and out-of-range address bits are intentionally dropped.
    assign unused_addr = ^iDTL_DMEM_Address;

    assign wr_beat     = !iReset && (state_q == WRITE) && iDTL_DMEM_WriteValid;
    assign wr_final    = (left_q == CNT_W'(1));
    assign rd_valid    = !iReset && (fifo_cnt_q != 2'd0);
    assign rd_pop      = rd_valid && iDTL_DMEM_ReadAccept;
    assign occupancy_d = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, rd_pop};
    assign rd_issue    = !iReset && (state_q == READ) && (left_q != '0) && (occupancy_d < 3'd2);

    assign oDTL_DMEM_CommandAccept = !iReset && (state_q == IDLE);
    assign oDTL_DMEM_WriteAccept   = !iReset && (state_q == WRITE);
    assign oMem_WriteEnable        = wr_beat ? iDTL_DMEM_WriteEnable : '0;
    assign oMem_WriteAddress       = wr_beat ? addr_q : '0;
    assign oMem_WriteData          = wr_beat ? iDTL_DMEM_WriteData : '0;
    assign oMem_ReadEnable         = rd_issue;
    assign oMem_ReadAddress        = rd_issue ? addr_q : '0;
    assign oDTL_DMEM_ReadValid     = rd_valid;
    assign oDTL_DMEM_ReadData      = rd_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign oDTL_DMEM_ReadLast      = rd_valid && fifo_last_q[rd_ptr_q];
    assign oError                  = !iReset && error_q;

    always_ff @(posedge iClk) begin
        if (inflight_q) begin
            fifo_data_q[wr_ptr_q] <= iMem_ReadData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_last_q     <= 2'b00;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            error_q         <= 1'b0;
        end else begin
            // SRAM data returns one cycle after issue; the last flag travels with it.
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && wr_final;
            if (inflight_q) begin
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (rd_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, rd_pop};

            case (state_q)
                IDLE: begin
                    if (iDTL_DMEM_CommandValid) begin
                        addr_q  <= iDTL_DMEM_Address[GM_MEM_ADDR_WIDTH+1:2];
                        left_q  <= {1'b0, iDTL_DMEM_BlockSize} + CNT_W'(1);
                        state_q <= iDTL_DMEM_CommandReadWrite ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (iDTL_DMEM_WriteValid) begin
                        addr_q <= addr_q + 1'b1;
                        left_q <= left_q - CNT_W'(1);
                        if (iDTL_DMEM_WriteLast != wr_final) begin
                            error_q <= 1'b1;
                        end
                        if (wr_final) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + 1'b1;
                        left_q <= left_q - CNT_W'(1);
                    end
                    if (rd_pop && fifo_last_q[rd_ptr_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dtl_gm_responder.sv
// Bench for dtl_gm_responder: table of directed transfers, multi-cycle corner sequences and random traffic
// checked against a word-array memory model and an SRAM model attached to the memory port.
module tb_dtl_gm_responder;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int BW    = 5;
    localparam int MW    = 10;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 1 << MW;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    logic            cvalid, caccept, crw;
    logic [AW-1:0]   caddr;
    logic [BW-1:0]   cbsize;
    logic            wvalid, waccept, wlast;
    logic [DW-1:0]   wdata;
    logic [BEW-1:0]  wen;
    logic            rvalid, raccept, rlast;
    logic [DW-1:0]   rdata;
    logic [MW-1:0]   mem_waddr, mem_raddr;
    logic [BEW-1:0]  mem_we;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_re;
    logic            err;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            acc_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        int          bsize;
        logic [31:0] data0;
        logic [3:0]  be;
        int          last_at;
        int          acc_mode;
        bit          exp_err;
        logic [31:0] exp_first;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    dtl_gm_responder #(
        .INTERFACE_WIDTH(DW), .INTERFACE_ADDR_WIDTH(AW),
        .INTERFACE_BLOCK_WIDTH(BW), .GM_MEM_ADDR_WIDTH(MW)
    ) dut (
        .iClk(clk), .iReset(rst),
        .iDTL_DMEM_CommandValid(cvalid), .oDTL_DMEM_CommandAccept(caccept),
        .iDTL_DMEM_CommandReadWrite(crw), .iDTL_DMEM_Address(caddr),
        .iDTL_DMEM_BlockSize(cbsize),
        .iDTL_DMEM_WriteValid(wvalid), .oDTL_DMEM_WriteAccept(waccept),
        .iDTL_DMEM_WriteData(wdata), .iDTL_DMEM_WriteEnable(wen),
        .iDTL_DMEM_WriteLast(wlast),
        .oDTL_DMEM_ReadValid(rvalid), .iDTL_DMEM_ReadAccept(raccept),
        .oDTL_DMEM_ReadData(rdata), .oDTL_DMEM_ReadLast(rlast),
        .oMem_WriteAddress(mem_waddr), .oMem_WriteEnable(mem_we),
        .oMem_WriteData(mem_wdata), .oMem_ReadAddress(mem_raddr),
        .oMem_ReadEnable(mem_re), .iMem_ReadData(mem_rdata),
        .oError(err)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // Synchronous SRAM: byte-strobed writes, registered read data.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < BEW; b++)
                if (mem_we[b]) sram[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_re) mem_rdata <= sram[mem_raddr];
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_write(input int w, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        for (int b = 0; b < BEW; b++)
            if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic do_cmd(input bit rw, input logic [31:0] addr, input int bsize);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        cvalid = 1'b1; crw = rw; caddr = addr; cbsize = BW'(bsize);
        @(negedge clk);
        while (!caccept && waited < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        check("cmd_accept", caccept, 1);
        @(posedge clk); #1;
        cvalid = 1'b0; crw = 1'b0; caddr = $urandom; cbsize = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int bsize, input logic [31:0] data0,
                            input logic [3:0] be0, input int last_at, input bit rnd,
                            output logic [MW-1:0] first_waddr);
        int base, w;
        logic [DW-1:0] d;
        logic [BEW-1:0] be;
        base = int'((addr >> 2) % DEPTH);
        first_waddr = '0;
        do_cmd(1'b1, addr, bsize);
        for (int i = 0; i <= bsize; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge clk);
                check("wr_gap_strobe", mem_we, 0);
                check("wr_gap_accept", waccept, 1);
                @(posedge clk); #1;
            end
            d  = rnd ? $urandom : data0 + 32'(i);
            be = rnd ? BEW'($urandom_range(0, 15)) : be0;
            w  = (base + i) % DEPTH;
            wvalid = 1'b1; wdata = d; wen = be; wlast = (i == last_at);
            @(negedge clk);
            if (i == 0) begin
                check("wr_cmd_accept_low", caccept, 0);
                first_waddr = mem_waddr;
            end
            check("wr_accept", waccept, 1);
            check("wr_addr", mem_waddr, w);
            check("wr_strobe", mem_we, be);
            check("wr_data", mem_wdata, d);
            model_write(w, d, be);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; wen = '0;
        @(negedge clk);
        check("wr_done_cmd_accept", caccept, 1);
        check("wr_done_no_strobe", mem_we, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int bsize, input int mode,
                           output logic [DW-1:0] first_data);
        int base, i, cyc, first, issued, max_out, last_cyc;
        bit acc;
        base = int'((addr >> 2) % DEPTH);
        i = 0; cyc = 0; first = -1; issued = 0; max_out = 0; last_cyc = -1;
        first_data = '0;
        do_cmd(1'b0, addr, bsize);
        while (last_cyc < 0 && cyc < 300) begin
            cyc++;
            acc = (mode == 0) ? 1'b1 : (mode == 1) ? acc_pat[(cyc - 1) % 7] : 1'($urandom_range(0, 1));
            raccept = acc;
            @(negedge clk);
            if (cyc == 1) check("rd_cmd_accept_low", caccept, 0);
            if (mem_re) issued++;
            if (rvalid) begin
                if (first < 0) begin
                    first = cyc;
                    first_data = rdata;
                end
                check("rd_data", rdata, ref_mem[(base + i) % DEPTH]);
                check("rd_last", rlast, (i == bsize));
                if (acc) begin
                    i++;
                    if (i > bsize) last_cyc = cyc;
                end
            end
            if (issued - i > max_out) max_out = issued - i;
            @(posedge clk); #1;
        end
        raccept = 1'b0;
        check("rd_complete", i, bsize + 1);
        check("rd_first_latency", first, 3);
        check("rd_outstanding_le2", (max_out <= 2), 1);
        check("rd_issue_count", issued, bsize + 1);
        if (mode == 0) check("rd_no_bubbles", last_cyc, 3 + bsize);
        @(negedge clk);
        check("rd_done_cmd_accept", caccept, 1);
        check("rd_done_no_valid", rvalid, 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {caccept, waccept, rvalid, rlast, mem_re, err, mem_waddr, mem_raddr, mem_we}, 0);
        check({name, "_data"}, {rdata, mem_wdata}, 0);
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [MW-1:0] fw;
        logic [DW-1:0] fd;
        int i, cyc, bs;
        logic [31:0] a, last_wr_addr;

        vecs[0]  = '{1'b1, 32'h0000_0040, 0, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 32'h010};
        vecs[1]  = '{1'b0, 32'h0000_0040, 0, 32'h0,       4'h0, 0, 0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0100, 3, 32'h1,       4'hF, 3, 0, 1'b0, 32'h040};
        vecs[3]  = '{1'b0, 32'h0000_0100, 3, 32'h0,       4'h0, 0, 1, 1'b0, 32'h1};
        vecs[4]  = '{1'b1, 32'h0000_0FF8, 3, 32'hA0,      4'hF, 3, 0, 1'b0, 32'h3FE};
        vecs[5]  = '{1'b0, 32'h0000_0FF8, 3, 32'h0,       4'h0, 0, 0, 1'b0, 32'hA0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 0, 32'h11223344, 4'hF, 0, 0, 1'b0, 32'h080};
        vecs[7]  = '{1'b1, 32'h0000_0202, 0, 32'hAABBCCDD, 4'h3, 0, 0, 1'b0, 32'h080};
        vecs[8]  = '{1'b0, 32'h0000_0200, 0, 32'h0,       4'h0, 0, 0, 1'b0, 32'h1122CCDD};
        vecs[9]  = '{1'b1, 32'h0000_0300, 3, 32'h70,      4'hF, 2, 0, 1'b1, 32'h0C0};
        vecs[10] = '{1'b0, 32'h0000_0300, 3, 32'h0,       4'h0, 0, 2, 1'b1, 32'h70};
        vecs[11] = '{1'b1, 32'hFFFF_F010, 1, 32'h55,      4'hF, 1, 0, 1'b1, 32'h004};
        vecs[12] = '{1'b0, 32'h0000_0010, 1, 32'h0,       4'h0, 0, 0, 1'b1, 32'h55};

        rst = 1'b1; preload = 1'b1;
        cvalid = 1'b0; crw = 1'b0; caddr = '0; cbsize = '0;
        wvalid = 1'b0; wdata = '0; wen = '0; wlast = 1'b0; raccept = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
        @(posedge clk); #1;
        preload = 1'b0;
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_accept", caccept, 1);
        check("idle_write_accept", waccept, 0);
        check("idle_read_valid", rvalid, 0);
        check("idle_error", err, 0);

        for (int k = 0; k < NV; k++) begin
            if (vecs[k].rw) begin
                do_write(vecs[k].addr, vecs[k].bsize, vecs[k].data0, vecs[k].be, vecs[k].last_at, 1'b0, fw);
                check("vec_first_waddr", fw, vecs[k].exp_first);
            end else begin
                do_read(vecs[k].addr, vecs[k].bsize, vecs[k].acc_mode, fd);
                check("vec_first_rdata", fd, vecs[k].exp_first);
            end
            check("vec_error", err, vecs[k].exp_err);
        end

        // Reset in the middle of an 8-beat read, after the second beat is consumed.
        do_cmd(1'b0, 32'h0000_0800, 7);
        i = 0; cyc = 0;
        while (i < 2 && cyc < 50) begin
            cyc++;
            raccept = 1'b1;
            @(negedge clk);
            if (rvalid) begin
                check("rst_pre_data", rdata, ref_mem[32'h200 + i]);
                i++;
            end
            @(posedge clk); #1;
        end
        check("rst_pre_pops", i, 2);
        rst = 1'b1; cvalid = 1'b1; wvalid = 1'b1; wen = '1; raccept = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid_outputs");
        @(posedge clk); #1;
        rst = 1'b0; cvalid = 1'b0; wvalid = 1'b0; wen = '0;
        @(negedge clk);
        check("rst_cmd_accept", caccept, 1);
        check("rst_no_valid", rvalid, 0);
        check("rst_error_clear", err, 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_no_stale_valid", rvalid, 0);
        end
        raccept = 1'b0;
        do_read(32'h0000_0804, 0, 0, fd);
        check("rst_follow_read", fd, init_word(32'h201));

        last_wr_addr = 32'h0;
        for (int n = 0; n < 40; n++) begin
            bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom;
                last_wr_addr = a;
                do_write(a, bs, 32'h0, 4'h0, bs, 1'b1, fw);
            end else begin
                a = ($urandom_range(0, 1) == 1) ? last_wr_addr : $urandom;
                do_read(a, bs, int'($urandom_range(0, 2)), fd);
            end
        end
        check("final_error_clear", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
